// File: rtl/clock_pkg.sv
// Shared constants for the seven-segment display path: digit geometry and
// active-low segment patterns ordered {g,f,e,d,c,b,a}.
package clock_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // Entry n holds the pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational nibble to active-low seven-segment decoder; non-decimal codes
// render as a dash.
module bcd_to_7seg
  import clock_pkg::*;
(
  input  logic [DIGIT_W-1:0] code,
  output logic [6:0]         seg
);

  // Table lookup for 0..9, dash for 10..15.
  always_comb begin
    seg = SEG_DASH;
    if (code < 4'd10) begin
      seg = SEG_TABLE[code];
    end else begin
      seg = SEG_DASH;
    end
  end

endmodule

// File: rtl/segment_scanner.sv
// Time-multiplexed driver for a common-anode 4-digit display with per-frame
// snapshot, leading-zero blanking, per-digit blink and an inter-digit gap.
module segment_scanner
  import clock_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   seg_data,
  input  logic                            blank_lz,
  input  logic [NUM_DIGITS-1:0]           blink_mask,
  output logic [NUM_DIGITS-1:0]           an,
  output logic [6:0]                      seg,
  output logic                            frame_start
);

  localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  logic [PRESC_W-1:0]            presc_r;
  logic [1:0]                    idx_r;
  logic [FRAME_W-1:0]            frame_cnt_r;
  logic                          blink_phase_r;
  logic [NUM_DIGITS*DIGIT_W-1:0] snap_r;
  logic                          load_pending_r;
  logic [NUM_DIGITS-1:0]         an_r;
  logic [6:0]                    seg_r;
  logic                          frame_start_r;

  logic                          tick_s;
  logic                          frame_end_s;
  logic                          load_s;
  logic [DIGIT_W-1:0]            nibble_s;
  logic [6:0]                    dec_seg_s;
  logic                          lz_s;
  logic                          suppress_s;
  logic [NUM_DIGITS-1:0]         an_next_s;
  logic [6:0]                    seg_next_s;

  assign tick_s      = (presc_r == PRESC_LAST);
  assign frame_end_s = tick_s && (idx_r == 2'd3);
  assign load_s      = frame_end_s || load_pending_r;

  // Nibble selection and leading-zero test for the digit being scanned.
  always_comb begin
    nibble_s = snap_r[3:0];
    lz_s     = 1'b0;
    case (idx_r)
      2'd0: begin
        nibble_s = snap_r[3:0];
        lz_s     = 1'b0;
      end
      2'd1: begin
        nibble_s = snap_r[7:4];
        lz_s     = (snap_r[15:12] == 4'd0) && (snap_r[11:8] == 4'd0) && (snap_r[7:4] == 4'd0);
      end
      2'd2: begin
        nibble_s = snap_r[11:8];
        lz_s     = (snap_r[15:12] == 4'd0) && (snap_r[11:8] == 4'd0);
      end
      2'd3: begin
        nibble_s = snap_r[15:12];
        lz_s     = (snap_r[15:12] == 4'd0);
      end
      default: begin
        nibble_s = snap_r[3:0];
        lz_s     = 1'b0;
      end
    endcase
  end

  assign suppress_s = (blink_mask[idx_r] && blink_phase_r) || (blank_lz && lz_s);

  bcd_to_7seg u_dec (
    .code (nibble_s),
    .seg  (dec_seg_s)
  );

  // Next output pattern: all-off during the tick gap, else the selected digit.
  always_comb begin
    an_next_s  = 4'b1111;
    seg_next_s = SEG_OFF;
    if (tick_s) begin
      an_next_s  = 4'b1111;
      seg_next_s = SEG_OFF;
    end else begin
      an_next_s = ~(4'b0001 << idx_r);
      if (suppress_s) begin
        seg_next_s = SEG_OFF;
      end else begin
        seg_next_s = dec_seg_s;
      end
    end
  end

  // Slot prescaler and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
      idx_r   <= 2'd0;
    end else if (tick_s) begin
      presc_r <= '0;
      idx_r   <= idx_r + 2'd1;
    end else begin
      presc_r <= presc_r + PRESC_W'(1);
    end
  end

  // Frame counter and blink phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else if (frame_end_s) begin
      if (frame_cnt_r == FRAME_LAST) begin
        frame_cnt_r   <= '0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
      end
    end
  end

  // Snapshot capture keeps a frame free of tearing from mid-frame updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_r         <= 16'h0000;
      load_pending_r <= 1'b1;
      frame_start_r  <= 1'b0;
    end else begin
      frame_start_r <= load_s;
      if (load_s) begin
        snap_r         <= seg_data;
        load_pending_r <= 1'b0;
      end
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r  <= 4'b1111;
      seg_r <= SEG_OFF;
    end else begin
      an_r  <= an_next_s;
      seg_r <= seg_next_s;
    end
  end

  assign an          = an_r;
  assign seg         = seg_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_segment_scanner.sv
// Directed bench for segment_scanner: a cycle model pushes expected outputs to
// a queue that is compared every cycle, plus directed digit checks.
module tb_segment_scanner;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam logic [6:0] OFF = 7'b1111111;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fs;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] seg_data = 16'h1234;
  logic        blank_lz = 1'b0;
  logic [3:0]  blink_mask = 4'b0000;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_start;

  int n_checks = 0;
  int n_errors = 0;

  out_t exp_q[$];

  int          m_presc = 0;
  int          m_idx = 0;
  int          m_fc = 0;
  logic        m_phase = 1'b0;
  logic        m_pend = 1'b1;
  logic [15:0] m_snap = 16'h0000;

  logic [6:0] d0 [8];
  logic [6:0] d1 [8];

  segment_scanner #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_data    (seg_data),
    .blank_lz    (blank_lz),
    .blink_mask  (blink_mask),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_dec(input logic [3:0] c);
    case (c)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic lz_sup(input int i, input logic [15:0] s);
    case (i)
      3: return s[15:12] == 4'd0;
      2: return s[15:8] == 8'd0;
      1: return s[15:4] == 12'd0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wait_an(input logic [3:0] target, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (an !== target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (an !== target) check({tag, "_timeout"}, {8'd0, an}, {8'd0, target});
  endtask

  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_frame_start"}, {11'd0, frame_start}, 12'd1);
  endtask

  task automatic expect_digit(input logic [3:0] a, input logic [6:0] s, input string tag);
    wait_an(a, tag);
    check(tag, {1'b0, an, seg}, {1'b0, a, s});
  endtask

  // Reference model state clears the moment reset is asserted.
  always @(negedge rst_n) begin
    m_presc = 0; m_idx = 0; m_fc = 0;
    m_phase = 1'b0; m_pend = 1'b1; m_snap = 16'h0000;
  end

  // Reference model: predict what the DUT presents after this edge.
  always @(posedge clk) begin
    out_t e;
    logic tick, fe, sup;
    if (!rst_n) begin
      e = {4'b1111, OFF, 1'b0};
    end else begin
      tick = (m_presc == SD - 1);
      fe   = tick && (m_idx == 3);
      sup  = (blink_mask[m_idx] && m_phase) || (blank_lz && lz_sup(m_idx, m_snap));
      e.fs = fe || m_pend;
      if (tick) begin
        e.an  = 4'b1111;
        e.seg = OFF;
      end else begin
        e.an         = 4'b1111;
        e.an[m_idx]  = 1'b0;
        e.seg        = sup ? OFF : ref_dec(m_snap[m_idx*4 +: 4]);
      end
      m_presc = tick ? 0 : m_presc + 1;
      if (tick) m_idx = (m_idx + 1) % 4;
      if (fe) begin
        if (m_fc == BF - 1) begin
          m_fc = 0;
          m_phase = ~m_phase;
        end else begin
          m_fc = m_fc + 1;
        end
      end
      if (e.fs) begin
        m_snap = seg_data;
        m_pend = 1'b0;
      end
    end
    exp_q.push_back(e);
  end

  // Scoreboard compare on the opposite edge.
  always @(negedge clk) begin
    out_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard", {an, seg, frame_start}, e);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", {an, seg, frame_start}, {4'b1111, OFF, 1'b0});
    rst_n = 1'b1;

    // First frame after release.
    @(negedge clk);
    check("first_frame_start", {7'd0, an, frame_start}, {7'd0, 4'b1110, 1'b1});
    @(negedge clk);
    check("digit0_4", {an, seg, frame_start}, {4'b1110, 7'b0011001, 1'b0});
    repeat (2) @(negedge clk);
    check("gap", {1'b0, an, seg}, {1'b0, 4'b1111, OFF});
    expect_digit(4'b1101, 7'b0110000, "digit1_3");

    // Mid-frame data change must not tear the current frame.
    seg_data = 16'h5678;
    expect_digit(4'b1011, 7'b0100100, "iso_digit2_2");
    expect_digit(4'b0111, 7'b1111001, "iso_digit3_1");
    wait_fs("iso");
    check("fs_in_gap", {8'd0, an}, {8'd0, 4'b1111});
    expect_digit(4'b1110, 7'b0000000, "iso_digit0_8");

    // Leading-zero blanking.
    seg_data = 16'h0005;
    blank_lz = 1'b1;
    wait_fs("lz");
    expect_digit(4'b1110, 7'b0010010, "lz_digit0_5");
    expect_digit(4'b1101, OFF, "lz_digit1_off");
    expect_digit(4'b1011, OFF, "lz_digit2_off");
    expect_digit(4'b0111, OFF, "lz_digit3_off");
    seg_data = 16'h0000;
    wait_fs("lz0");
    expect_digit(4'b1110, 7'b1000000, "lz0_digit0_0");
    expect_digit(4'b1101, OFF, "lz0_digit1_off");

    // Blink digit 0 with two frames per phase.
    seg_data = 16'h1234;
    blank_lz = 1'b0;
    blink_mask = 4'b0001;
    wait_fs("blink");
    for (int k = 0; k < 8; k++) begin
      wait_an(4'b1110, "blink_d0");
      d0[k] = seg;
      wait_an(4'b1101, "blink_d1");
      d1[k] = seg;
      check("blink_other_digit", {5'd0, d1[k]}, {5'd0, 7'b0110000});
      check("blink_d0_value", {11'd0, (d0[k] === 7'b0011001) || (d0[k] === OFF)}, 12'd1);
    end
    for (int k = 0; k < 6; k++) begin
      check("blink_alternate", {11'd0, d0[k] !== d0[k+2]}, 12'd1);
    end

    // Non-decimal codes render as dashes.
    blink_mask = 4'b0000;
    seg_data = 16'hA0F0;
    wait_fs("inv");
    expect_digit(4'b1110, 7'b1000000, "inv_digit0_0");
    expect_digit(4'b1101, 7'b0111111, "inv_digit1_dash");
    expect_digit(4'b1011, 7'b1000000, "inv_digit2_0");
    expect_digit(4'b0111, 7'b0111111, "inv_digit3_dash");

    // Asynchronous reset in the middle of digit 2.
    seg_data = 16'h0009;
    wait_an(4'b1011, "arst_wait");
    #2 rst_n = 1'b0;
    #1 check("async_reset", {an, seg, frame_start}, {4'b1111, OFF, 1'b0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_restart", {7'd0, an, frame_start}, {7'd0, 4'b1110, 1'b1});
    @(negedge clk);
    check("arst_digit0_9", {1'b0, an, seg}, {1'b0, 4'b1110, 7'b0010000});

    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
